// File: rtl/cpu_dmem_responder_if.sv
// CPU data-bus bundle between the execute/memory stages and the responder.
// master = CPU side (drives requests), slave = responder (drives acks).
interface cpu_dmem_responder_if;
   logic        cpu_request;
   logic [31:0] cpu_addr;
   logic        cpu_write;
   logic [3:0]  cpu_byte_enable;
   logic [31:0] cpu_wdata;
   logic [1:0]  cpu_size;
   logic        cpu_ack;
   logic [31:0] cpu_rdata;
   logic        cpu_error;
   logic        overflow;

   modport master (
      output cpu_request, cpu_addr, cpu_write,
      output cpu_byte_enable, cpu_wdata, cpu_size,
      input  cpu_ack, cpu_rdata, cpu_error, overflow
   );

   modport slave (
      input  cpu_request, cpu_addr, cpu_write,
      input  cpu_byte_enable, cpu_wdata, cpu_size,
      output cpu_ack, cpu_rdata, cpu_error, overflow
   );
endinterface

// File: rtl/cpu_dmem_responder.sv
// Data-RAM responder: 2-entry request FIFO, in-order service, wait states.
// Ports: clock, reset (sync, active-high), bus (slave: request in, ack out).
module cpu_dmem_responder #(
   parameter int unsigned ADDR_BITS   = 14,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int unsigned WAIT_STATES = 0
) (
   input logic                 clock,
   input logic                 reset,
   cpu_dmem_responder_if.slave bus
);
   localparam int unsigned IW    = ADDR_BITS - 2;
   localparam int unsigned WORDS = 2 ** IW;

   typedef struct packed {
      logic [31:0] addr;
      logic        write;
      logic [3:0]  be;
      logic [31:0] wdata;
      logic [1:0]  size;
   } req_t;

   typedef enum logic [1:0] {
      S_IDLE, S_ACCESS, S_RESP, S_ERR
   } state_t;

   req_t        r_fifo [2];
   logic        r_wr_ptr;
   logic        r_rd_ptr;
   logic [1:0]  r_count;
   logic        r_ovf;
   req_t        r_hold;
   state_t      r_state;
   state_t      w_next;
   logic [3:0]  r_wait;
   logic [31:0] r_ram_q;
   logic [31:0] r_mem [WORDS];
   logic        r_ack;
   logic        r_err;
   logic [31:0] r_rdata;

   req_t        w_in;
   req_t        w_head;
   logic        w_pop;
   logic        w_push;
   logic        w_drop;
   logic        w_head_bad;
   logic        w_do_ram;
   logic [IW-1:0] w_idx;
   logic        w_ack;
   logic        w_err;
   logic [31:0] w_rdata;
   logic        w_unused;

   assign w_in = '{addr:  bus.cpu_addr,
                   write: bus.cpu_write,
                   be:    bus.cpu_byte_enable,
                   wdata: bus.cpu_wdata,
                   size:  bus.cpu_size};

   assign w_head = r_fifo[r_rd_ptr];
   assign w_pop  = (r_state == S_IDLE) && (r_count != 2'd0);
   // A full FIFO still accepts when the head leaves in the same cycle.
   assign w_push = bus.cpu_request && ((r_count != 2'd2) || w_pop);
   assign w_drop = bus.cpu_request && !w_push;

   assign w_head_bad =
      (w_head.addr[31:ADDR_BITS] != BASE_ADDR[31:ADDR_BITS]) ||
      (w_head.size == 2'b11);

   assign w_do_ram = (r_state == S_ACCESS) && (r_wait == 4'd0);
   assign w_idx    = r_hold.addr[ADDR_BITS-1:2];

   assign w_unused = ^{r_hold.addr[1:0], r_hold.addr[31:ADDR_BITS],
                       r_hold.size};

   always_ff @(posedge clock) begin
      if (reset) begin
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
         r_count  <= 2'd0;
         r_ovf    <= 1'b0;
      end else begin
         if (w_push) r_wr_ptr <= ~r_wr_ptr;
         if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
         r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
         if (w_drop) r_ovf <= 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (w_push) r_fifo[r_wr_ptr] <= w_in;
      if (w_pop)  r_hold <= w_head;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_wait  <= 4'd0;
      end else begin
         r_state <= w_next;
         if (w_pop)
            r_wait <= 4'(WAIT_STATES);
         else if (r_state == S_ACCESS && r_wait != 4'd0)
            r_wait <= r_wait - 4'd1;
      end
   end

   always_comb begin
      w_next  = r_state;
      w_ack   = 1'b0;
      w_err   = 1'b0;
      w_rdata = '0;
      unique case (r_state)
         S_IDLE: begin
            if (w_pop) w_next = w_head_bad ? S_ERR : S_ACCESS;
         end
         S_ACCESS: begin
            if (r_wait == 4'd0) w_next = S_RESP;
         end
         S_RESP: begin
            w_ack   = 1'b1;
            w_rdata = r_hold.write ? 32'd0 : r_ram_q;
            w_next  = S_IDLE;
         end
         S_ERR: begin
            w_ack  = 1'b1;
            w_err  = 1'b1;
            w_next = S_IDLE;
         end
      endcase
   end

   // RAM has no reset so its contents survive a bus reset.
   always_ff @(posedge clock) begin
      if (w_do_ram && !reset) begin
         if (r_hold.write) begin
            for (int i = 0; i < 4; i++) begin
               if (r_hold.be[i])
                  r_mem[w_idx][8*i +: 8] <= r_hold.wdata[8*i +: 8];
            end
         end else begin
            r_ram_q <= r_mem[w_idx];
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_ack   <= 1'b0;
         r_err   <= 1'b0;
         r_rdata <= '0;
      end else begin
         r_ack   <= w_ack;
         r_err   <= w_err;
         r_rdata <= w_rdata;
      end
   end

   assign bus.cpu_ack   = r_ack;
   assign bus.cpu_error = r_err;
   assign bus.cpu_rdata = r_rdata;
   assign bus.overflow  = r_ovf;
endmodule
